// File: rtl/board_pkg.sv
// Shared definitions for the board gravity engine: default geometry, the empty
// cell encoding, the FSM state type, the refill LFSR taps and the cell index helper.
package board_pkg;

  localparam int unsigned DEF_ROWS   = 8;
  localparam int unsigned DEF_COLS   = 8;
  localparam int unsigned DEF_CELL_W = 3;

  // Cell value meaning "cleared / nothing here".
  localparam int unsigned EMPTY = 0;

  // 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1 (bits 15,13,12,10).
  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Flat cell index of (row, col); the cell occupies bits [idx*CELL_W +: CELL_W].
  function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/column_compact.sv
// Combinational gravity for one board column.
// Ports:
//   col_in     : ROWS cells, row 0 (top) in the low bits
//   refill     : ROWS candidate refill colours, same layout as col_in
//   refill_en  : 1 = vacated top cells take the refill colour, 0 = they stay empty
//   col_out    : compacted column, non-empty cells packed to the bottom in order
//   zero_count : number of empty cells in col_in
module column_compact
  import board_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned CELL_W = DEF_CELL_W
) (
  input  logic [ROWS*CELL_W-1:0]      col_in,
  input  logic [ROWS*CELL_W-1:0]      refill,
  input  logic                        refill_en,
  output logic [ROWS*CELL_W-1:0]      col_out,
  output logic [$clog2(ROWS+1)-1:0]   zero_count
);

  localparam int unsigned ZW = $clog2(ROWS + 1);

  // Walk bottom-up, dropping each non-empty cell into the next free slot from the bottom.
  always_comb begin
    int wp;
    int nz;
    col_out = '0;
    wp      = int'(ROWS) - 1;
    nz      = 0;
    for (int r = int'(ROWS) - 1; r >= 0; r--) begin
      if (col_in[r*CELL_W +: CELL_W] != CELL_W'(EMPTY)) begin
        col_out[wp*CELL_W +: CELL_W] = col_in[r*CELL_W +: CELL_W];
        wp = wp - 1;
      end else begin
        nz = nz + 1;
      end
    end
    // The top nz rows are the vacated ones.
    for (int r = 0; r < int'(ROWS); r++) begin
      if (r < nz) begin
        col_out[r*CELL_W +: CELL_W] = refill_en ? refill[r*CELL_W +: CELL_W] : CELL_W'(EMPTY);
      end
    end
    zero_count = ZW'(nz);
  end

endmodule

// File: rtl/board_gravity_engine.sv
// Sequential board gravity: compacts one column per clock, optionally refills
// vacated cells from an LFSR, and publishes the result with a start/done handshake.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, accepted only while ready
//   refill_en   : sampled with start; 1 = fill vacated cells with colours
//   board_in    : ROWS x COLS cells, cell(r,c) at [(r*COLS+c)*CELL_W +: CELL_W]
//   ready       : idle and able to accept start
//   busy        : scanning or publishing
//   done        : one-cycle pulse, board_out/empty_count valid from this cycle
//   board_out   : result board, held until the next done
//   empty_count : number of empty cells in the accepted board
module board_gravity_engine
  import board_pkg::*;
#(
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned CELL_W     = DEF_CELL_W,
  parameter int unsigned NUM_COLORS = 7,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              refill_en,
  input  logic [ROWS*COLS*CELL_W-1:0]       board_in,
  output logic                              ready,
  output logic                              busy,
  output logic                              done,
  output logic [ROWS*COLS*CELL_W-1:0]       board_out,
  output logic [$clog2(ROWS*COLS+1)-1:0]    empty_count
);

  localparam int unsigned BW    = ROWS * COLS * CELL_W;
  localparam int unsigned CLW   = ROWS * CELL_W;
  localparam int unsigned ZW    = $clog2(ROWS + 1);
  localparam int unsigned ECW   = $clog2(ROWS * COLS + 1);
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [COL_W-1:0]  col;
  logic              last_col;
  logic [BW-1:0]     work;
  logic              refill_q;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_step;
  logic [ECW-1:0]    acc;

  logic [CLW-1:0]    col_cells;
  logic [CLW-1:0]    col_fill;
  logic [CLW-1:0]    col_packed;
  logic [ZW-1:0]     col_zeros;

  logic              accept;
  logic              scan;
  logic              publish;
  logic              ready_d;
  logic              busy_d;
  logic              done_d;

  assign last_col  = (col == COL_W'(COLS - 1));
  assign lfsr_step = {lfsr[14:0], ^(lfsr & LFSR_TAPS)};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_col) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode; status flags are registered from the next state.
  always_comb begin
    accept  = 1'b0;
    scan    = 1'b0;
    publish = 1'b0;
    case (state)
      IDLE:    accept  = start;
      SCAN:    scan    = 1'b1;
      DONE:    publish = 1'b1;
      default: ;
    endcase
    ready_d = (state_nxt == IDLE);
    busy_d  = ~ready_d;
    done_d  = publish;
  end

  // Select the column currently being scanned out of the work register.
  always_comb begin
    col_cells = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      col_cells[r*CELL_W +: CELL_W] = work[cell_idx(r, 32'(col), COLS)*CELL_W +: CELL_W];
    end
  end

  // Refill colour for row r: CELL_W LFSR bits starting at r*CELL_W (wrapping mod 16),
  // mapped into 1..NUM_COLORS so a refilled cell is never empty.
  always_comb begin
    logic [CELL_W-1:0] raw;
    col_fill = '0;
    raw      = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned b = 0; b < CELL_W; b++) begin
        raw[b] = lfsr[(r*CELL_W + b) % LFSR_W];
      end
      col_fill[r*CELL_W +: CELL_W] = CELL_W'((32'(raw) % NUM_COLORS) + 32'd1);
    end
  end

  column_compact #(
    .ROWS   (ROWS),
    .CELL_W (CELL_W)
  ) u_compact (
    .col_in     (col_cells),
    .refill     (col_fill),
    .refill_en  (refill_q),
    .col_out    (col_packed),
    .zero_count (col_zeros)
  );

  // Datapath: work register, column counter, LFSR, empty accumulator, outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      board_out   <= '0;
      empty_count <= '0;
      work        <= '0;
      refill_q    <= 1'b0;
      lfsr        <= LFSR_SEED;
      acc         <= '0;
      col         <= '0;
    end else begin
      ready <= ready_d;
      busy  <= busy_d;
      done  <= done_d;

      if (accept) begin
        work     <= board_in;
        refill_q <= refill_en;
        acc      <= '0;
        col      <= '0;
      end

      if (scan) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          work[cell_idx(r, 32'(col), COLS)*CELL_W +: CELL_W] <= col_packed[r*CELL_W +: CELL_W];
        end
        acc <= acc + ECW'(col_zeros);
        if (refill_q) lfsr <= lfsr_step;
        col <= last_col ? '0 : col + COL_W'(1);
      end

      if (publish) begin
        board_out   <= work;
        empty_count <= acc;
      end
    end
  end

endmodule

// File: tb/tb_board_gravity_engine.sv
module tb_board_gravity_engine;

  localparam int unsigned R   = 8;
  localparam int unsigned C   = 8;
  localparam int unsigned W   = 3;
  localparam int unsigned BW  = R * C * W;
  localparam int unsigned ECW = $clog2(R * C + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           refill_en;
  logic [BW-1:0]  board_in;
  logic           ready;
  logic           busy;
  logic           done;
  logic [BW-1:0]  board_out;
  logic [ECW-1:0] empty_count;

  always #5 clk = ~clk;

  board_gravity_engine #(
    .ROWS       (R),
    .COLS       (C),
    .CELL_W     (W),
    .NUM_COLORS (7),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .refill_en   (refill_en),
    .board_in    (board_in),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .board_out   (board_out),
    .empty_count (empty_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string         name;
    logic [BW-1:0] board;
    logic          refill;
    logic [BW-1:0] exp;
    int            exp_ec;
    bit            loose;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int unsigned r,
                                        input int unsigned c, input int unsigned v);
    logic [BW-1:0] t;
    t = b;
    t[(r*C + c)*W +: W] = W'(v);
    return t;
  endfunction

  function automatic int unsigned get(input logic [BW-1:0] b, input int unsigned r,
                                      input int unsigned c);
    logic [W-1:0] v;
    v = b[(r*C + c)*W +: W];
    return 32'(v);
  endfunction

  // Issue one request from IDLE and wait (bounded) for done; lat = cycles from accept edge.
  task automatic run_op(input logic [BW-1:0] b, input logic re, output logic [BW-1:0] res,
                        output logic [ECW-1:0] ec, output int lat);
    lat = -1;
    res = '0;
    ec  = '0;
    @(negedge clk);
    board_in  = b;
    refill_en = re;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    board_in  = ~b;
    refill_en = ~re;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        res = board_out;
        ec  = empty_count;
        break;
      end
    end
  endtask

  logic [BW-1:0]  b_rows, b_hole, e_hole, b_five, b_zero, b_top, e_top, mask, res;
  logic [ECW-1:0] ec;
  int             lat;
  int             nz;
  int             dones;
  int             t_done[$];
  int             hole_col[8];

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    refill_en = 1'b0;
    board_in  = '0;

    hole_col = '{0, 0, 1, 2, 3, 5, 6, 7};
    b_rows = '0; b_hole = '0; e_hole = '0; b_five = '0; b_zero = '0; b_top = '0; e_top = '0;
    for (int unsigned r = 0; r < R; r++) begin
      for (int unsigned c = 0; c < C; c++) begin
        b_rows = put(b_rows, r, c, r);
        b_hole = put(b_hole, r, c, (r == 4 || c == 4) ? 0 : r);
        e_hole = put(e_hole, r, c, (c == 4) ? 0 : 32'(hole_col[r]));
        b_five = put(b_five, r, c, 5);
        b_top  = put(b_top, r, c, (r == 0) ? (c % 7) + 1 : 0);
        e_top  = put(e_top, r, c, (r == 7) ? (c % 7) + 1 : 0);
      end
    end

    vecs[0] = '{"rows_norefill",   b_rows, 1'b0, b_rows, 8,  1'b0};
    vecs[1] = '{"hole_norefill",   b_hole, 1'b0, e_hole, 22, 1'b0};
    vecs[2] = '{"hole_refill",     b_hole, 1'b1, e_hole, 22, 1'b1};
    vecs[3] = '{"full_norefill",   b_five, 1'b0, b_five, 0,  1'b0};
    vecs[4] = '{"full_refill",     b_five, 1'b1, b_five, 0,  1'b0};
    vecs[5] = '{"empty_norefill",  b_zero, 1'b0, b_zero, 64, 1'b0};
    vecs[6] = '{"top_cell_falls",  b_top,  1'b0, e_top,  56, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset/ready", BW'(ready), BW'(1));
    chk("reset/busy", BW'(busy), BW'(0));
    chk("reset/done", BW'(done), BW'(0));
    chk("reset/board_out", board_out, '0);
    chk("reset/empty_count", BW'(empty_count), BW'(0));

    // Table-driven requests.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].board, vecs[i].refill, res, ec, lat);
      chk({vecs[i].name, "/latency"}, BW'(lat), BW'(9));
      chk({vecs[i].name, "/empty_count"}, BW'(ec), BW'(vecs[i].exp_ec));
      if (!vecs[i].loose) begin
        chk({vecs[i].name, "/board"}, res, vecs[i].exp);
      end else begin
        mask = '0;
        nz   = 0;
        for (int unsigned r = 0; r < R; r++) begin
          for (int unsigned c = 0; c < C; c++) begin
            if (r >= 2 && c != 4) mask = put(mask, r, c, 7);
            if (get(res, r, c) == 0) nz++;
          end
        end
        chk({vecs[i].name, "/kept_rows"}, res & mask, vecs[i].exp & mask);
        chk({vecs[i].name, "/no_empty_cells"}, BW'(nz), BW'(0));
      end
    end

    // Start while busy is ignored: exactly one done, result of the first request.
    @(negedge clk);
    board_in  = b_rows;
    refill_en = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    board_in = b_five;
    @(negedge clk);
    chk("busy_start/ready_low", BW'(ready), BW'(0));
    chk("busy_start/busy_high", BW'(busy), BW'(1));
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    res   = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        res = board_out;
      end
    end
    chk("busy_start/done_pulses", BW'(dones), BW'(1));
    chk("busy_start/board", res, b_rows);

    // Reset mid-scan aborts the request.
    @(negedge clk);
    board_in = b_hole;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort/ready", BW'(ready), BW'(1));
    chk("abort/busy", BW'(busy), BW'(0));
    chk("abort/done", BW'(done), BW'(0));
    chk("abort/board_out", board_out, '0);
    chk("abort/empty_count", BW'(empty_count), BW'(0));
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort/no_done", BW'(dones), BW'(0));

    // Start held high: back-to-back requests every COLS+2 cycles.
    @(negedge clk);
    board_in  = b_five;
    refill_en = 1'b0;
    start     = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done) begin
        t_done.push_back(i);
        chk("b2b/board", board_out, b_five);
        chk("b2b/empty_count", BW'(empty_count), BW'(0));
      end
    end
    start = 1'b0;
    chk("b2b/done_count", BW'(t_done.size()), BW'(3));
    if (t_done.size() >= 3) begin
      chk("b2b/first_done", BW'(t_done[0]), BW'(9));
      chk("b2b/spacing_1", BW'(t_done[1] - t_done[0]), BW'(10));
      chk("b2b/spacing_2", BW'(t_done[2] - t_done[1]), BW'(10));
    end
    repeat (15) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
